// File: rtl/ssd_tdm_scanner.sv
// ssd_tdm_scanner
// Scans an N-digit common-anode seven-segment display one digit slot at a time.
// Each slot opens with a short all-anodes-off guard to stop ghosting, then
// drives that digit's anode low and its code on bin_out. The code 4'hF blanks.
// The BCD value is latched once per frame, so every digit in a frame comes
// from the same snapshot. Outputs are registered from next-state values, which
// keeps them in step with the slot counter without decode glitches.

module ssd_tdm_scanner #(
   parameter int N_DIGITS     = 4,
   parameter int SCAN_DIV     = 100000,
   parameter int GUARD_CYCLES = 1000,
   localparam int IW          = $clog2(N_DIGITS),
   localparam int CW          = $clog2(SCAN_DIV)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [4*N_DIGITS-1:0] bcd_in,
   input  logic [N_DIGITS-1:0]   digit_en,
   input  logic                  lz_blank_en,
   output logic [3:0]            bin_out,
   output logic [N_DIGITS-1:0]   an,
   output logic [IW-1:0]         slot_idx
);

   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

   logic [CW-1:0]         cnt;
   logic [CW-1:0]         cnt_nxt;
   logic [IW-1:0]         idx;
   logic [IW-1:0]         idx_nxt;
   logic [4*N_DIGITS-1:0] shadow;
   logic [4*N_DIGITS-1:0] shadow_nxt;
   logic                  cnt_wrap;
   logic                  idx_wrap;
   logic                  show;
   logic                  run_zero;
   logic [N_DIGITS-1:0]   lead_zero;
   logic [3:0]            digit_sel;
   logic [N_DIGITS-1:0]   an_nxt;
   logic [3:0]            bin_nxt;

   // Next slot position; the snapshot is refreshed on the edge that enters slot 0.
   always_comb begin
      cnt_wrap   = (cnt == CNT_LAST);
      idx_wrap   = (idx == IDX_LAST);
      cnt_nxt    = cnt + 1'b1;
      idx_nxt    = idx;
      shadow_nxt = shadow;
      if (cnt_wrap) begin
         cnt_nxt = '0;
         if (idx_wrap) begin
            idx_nxt    = '0;
            shadow_nxt = bcd_in;
         end else begin
            idx_nxt = idx + 1'b1;
         end
      end
   end

   // Guard phase covers the first GUARD_CYCLES counts of every slot.
   generate
      if (GUARD_CYCLES == 0) begin : g_no_guard
         assign show = 1'b1;
      end else begin : g_guard
         assign show = (cnt_nxt >= CW'(GUARD_CYCLES));
      end
   endgenerate

   // Leading-zero map: lead_zero[i] is set when snapshot digits i..N-1 are all zero.
   always_comb begin
      run_zero  = 1'b1;
      lead_zero = '0;
      for (int i = N_DIGITS - 1; i >= 0; i--) begin
         run_zero     = run_zero & (shadow_nxt[4*i +: 4] == 4'h0);
         lead_zero[i] = run_zero;
      end
   end

   // Output decode for the upcoming (idx, cnt); digit 0 is never zero-suppressed.
   always_comb begin
      digit_sel = shadow_nxt[4*idx_nxt +: 4];
      an_nxt    = '1;
      bin_nxt   = 4'hF;
      if (show) begin
         an_nxt[idx_nxt] = 1'b0;
         if (!digit_en[idx_nxt]) begin
            bin_nxt = 4'hF;
         end else if (lz_blank_en && (idx_nxt != '0) && lead_zero[idx_nxt]) begin
            bin_nxt = 4'hF;
         end else begin
            bin_nxt = digit_sel;
         end
      end
   end

   // Slot state, snapshot and registered outputs all advance on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         idx     <= '0;
         shadow  <= '0;
         an      <= '1;
         bin_out <= 4'hF;
      end else begin
         cnt     <= cnt_nxt;
         idx     <= idx_nxt;
         shadow  <= shadow_nxt;
         an      <= an_nxt;
         bin_out <= bin_nxt;
      end
   end

   assign slot_idx = idx;

endmodule
